// File: rtl/shifter_pkg.sv
// ============================================================================
// Module   : shifter_pkg
// Purpose  : Opcode and FSM state encodings shared by the serial shifter
//            and its single-bit step sub-module.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package shifter_pkg;

  // Operation codes carried on shift_op
  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_LOAD = 3'b001;
  localparam logic [2:0] OP_SLL  = 3'b010;
  localparam logic [2:0] OP_SRL  = 3'b011;
  localparam logic [2:0] OP_SRA  = 3'b100;
  localparam logic [2:0] OP_ROR  = 3'b101;
  localparam logic [2:0] OP_ROL  = 3'b110;
  localparam logic [2:0] OP_RSVD = 3'b111;

  // Controller states
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  // True for the ops that iterate single-bit steps
  function automatic logic op_is_shift(input logic [2:0] op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA) ||
           (op == OP_ROR) || (op == OP_ROL);
  endfunction

  // NOP and the reserved code leave the result register untouched
  function automatic logic op_loads_data(input logic [2:0] op);
    return (op != OP_NOP) && (op != OP_RSVD);
  endfunction

endpackage

`default_nettype wire

// File: rtl/shift_step.sv
// ============================================================================
// Module   : shift_step
// Purpose  : Combinational single-bit shift/rotate of a 32-bit value.
//            Non-shifting codes pass the value through unchanged.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_step
  import shifter_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] value_in,
  output logic [31:0] value_out
);

  // One-bit move selected by the captured opcode
  always_comb begin
    value_out = value_in;
    case (op)
      OP_SLL:  value_out = {value_in[30:0], 1'b0};
      OP_SRL:  value_out = {1'b0, value_in[31:1]};
      OP_SRA:  value_out = {value_in[31], value_in[31:1]};
      OP_ROR:  value_out = {value_in[0], value_in[31:1]};
      OP_ROL:  value_out = {value_in[30:0], value_in[31]};
      default: value_out = value_in;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/serial_shifter.sv
// ============================================================================
// Module   : serial_shifter
// Purpose  : Multi-cycle 32-bit shifter applying one bit position per clock.
//            A start in IDLE captures operands; the result appears in
//            data_out and done pulses for one cycle on completion.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_shifter
  import shifter_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  shift_op,
  input  logic [31:0] data_in,
  input  logic [4:0]  shamt,
  output logic        busy,
  output logic        done,
  output logic [31:0] data_out
);

  logic [1:0]  state;
  logic [1:0]  state_next;
  logic [4:0]  count;
  logic [2:0]  op;
  logic [31:0] step_value;
  logic        busy_next;
  logic        done_next;
  logic        accept;

  // A start is only honoured while idle
  assign accept = (state == ST_IDLE) && start;

  shift_step u_step (
    .op        (op),
    .value_in  (data_out),
    .value_out (step_value)
  );

  // State register; busy/done are registered copies of the next-state decode
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= busy_next;
      done  <= done_next;
    end
  end

  // Next-state selection; zero-length shifts complete like a LOAD
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (start) begin
          if (op_is_shift(shift_op) && (shamt != 5'd0)) state_next = ST_SHIFT;
          else                                            state_next = ST_DONE;
        end
      end
      ST_SHIFT: begin
        if (count == 5'd1) state_next = ST_DONE;
      end
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Output decode of the upcoming state, registered above
  always_comb begin
    busy_next = (state_next != ST_IDLE);
    done_next = (state_next == ST_DONE);
  end

  // Operand capture and per-cycle shift step
  always_ff @(posedge clk) begin
    if (reset) begin
      data_out <= 32'd0;
      count    <= 5'd0;
      op       <= OP_NOP;
    end else if (accept) begin
      op    <= shift_op;
      count <= shamt;
      if (op_loads_data(shift_op)) data_out <= data_in;
    end else if (state == ST_SHIFT) begin
      data_out <= step_value;
      count    <= count - 5'd1;
    end
  end

endmodule

`default_nettype wire
